// File: rtl/regfile_issue_ctrl.sv
// Issue controller for a 2-read/1-write register file: it accepts one reg-reg instruction,
// reads both sources, runs a small ALU op and writes the destination. Each instruction takes 4 cycles.
module regfile_issue_ctrl #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [2:0]       Op,
   input  logic [AW-1:0]    Rd,
   input  logic [AW-1:0]    Rs1,
   input  logic [AW-1:0]    Rs2,
   output logic [AW-1:0]    Re1,
   output logic [AW-1:0]    Re2,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] D2,
   output logic [AW-1:0]    W,
   output logic [WIDTH-1:0] Da,
   output logic             We,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic             Carry,
   output logic             Zero
);

   typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

   localparam logic [2:0] OpAdd = 3'd0;
   localparam logic [2:0] OpSub = 3'd1;
   localparam logic [2:0] OpAnd = 3'd2;
   localparam logic [2:0] OpOr  = 3'd3;
   localparam logic [2:0] OpXor = 3'd4;
   localparam logic [2:0] OpShl = 3'd5;
   localparam logic [2:0] OpShr = 3'd6;
   localparam logic [2:0] OpMov = 3'd7;

   state_e           state_q;
   logic             rdy_q;
   logic [2:0]       op_q;
   logic [AW-1:0]    rd_q;
   logic [AW-1:0]    re1_q;
   logic [AW-1:0]    re2_q;
   logic [AW-1:0]    w_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH:0]   res_q;
   logic [WIDTH:0]   alu_d;
   logic             we_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             zero_q;

   // Bit WIDTH of the ALU result carries the carry/borrow/shift-out flag.
   always_comb begin
      alu_d = '0;
      case (op_q)
         OpAdd:   alu_d = {1'b0, a_q} + {1'b0, b_q};
         OpSub:   alu_d = {1'b0, a_q} - {1'b0, b_q};
         OpAnd:   alu_d = {1'b0, a_q & b_q};
         OpOr:    alu_d = {1'b0, a_q | b_q};
         OpXor:   alu_d = {1'b0, a_q ^ b_q};
         OpShl:   alu_d = {a_q, 1'b0};
         OpShr:   alu_d = {a_q[0], 1'b0, a_q[WIDTH-1:1]};
         OpMov:   alu_d = {1'b0, a_q};
         default: alu_d = '0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= StIdle;
         rdy_q    <= 1'b1;
         op_q     <= '0;
         rd_q     <= '0;
         re1_q    <= '0;
         re2_q    <= '0;
         w_q      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         we_q     <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (In_Valid && rdy_q) begin
                  op_q    <= Op;
                  rd_q    <= Rd;
                  re1_q   <= Rs1;
                  re2_q   <= Rs2;
                  rdy_q   <= 1'b0;
                  state_q <= StRead;
               end
            end
            StRead: begin
               a_q     <= D1;
               b_q     <= D2;
               state_q <= StExec;
            end
            StExec: begin
               res_q   <= alu_d;
               we_q    <= 1'b1;
               w_q     <= rd_q;
               state_q <= StWrite;
            end
            StWrite: begin
               result_q <= res_q[WIDTH-1:0];
               carry_q  <= res_q[WIDTH];
               zero_q   <= (res_q[WIDTH-1:0] == '0);
               done_q   <= 1'b1;
               rdy_q    <= 1'b1;
               state_q  <= StIdle;
            end
            default: begin
               rdy_q   <= 1'b1;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign In_Ready = rdy_q;
   assign Re1      = re1_q;
   assign Re2      = re2_q;
   assign W        = w_q;
   // Da holds the last computed value after WRITE.
   assign Da       = res_q[WIDTH-1:0];
   assign We       = we_q;
   assign Done     = done_q;
   assign Result   = result_q;
   assign Carry    = carry_q;
   assign Zero     = zero_q;

endmodule

// File: tb/tb_regfile_issue_ctrl.sv
// Directed bench for regfile_issue_ctrl with a behavioural 16x16 register file attached.
module tb_regfile_issue_ctrl;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        In_Valid = 1'b0;
   logic        In_Ready;
   logic [2:0]  Op = '0;
   logic [3:0]  Rd = '0;
   logic [3:0]  Rs1 = '0;
   logic [3:0]  Rs2 = '0;
   logic [3:0]  Re1;
   logic [3:0]  Re2;
   logic [15:0] D1;
   logic [15:0] D2;
   logic [3:0]  W;
   logic [15:0] Da;
   logic        We;
   logic        Done;
   logic [15:0] Result;
   logic        Carry;
   logic        Zero;

   int total = 0;
   int passed = 0;

   logic [15:0] rf [16];
   logic        pre_en = 1'b0;
   logic [3:0]  pre_addr = '0;
   logic [15:0] pre_data = '0;

   int          cyc = 0;
   int          wn = 0;
   int          an = 0;
   logic [3:0]  wlog_addr [64];
   logic [15:0] wlog_data [64];
   int          acc_cyc [64];

   always #5 Clk = ~Clk;

   regfile_issue_ctrl #(.WIDTH(16), .AW(4)) dut (
      .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
      .Op(Op), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
      .Re1(Re1), .Re2(Re2), .D1(D1), .D2(D2),
      .W(W), .Da(Da), .We(We), .Done(Done),
      .Result(Result), .Carry(Carry), .Zero(Zero)
   );

   assign D1 = rf[Re1];
   assign D2 = rf[Re2];

   always @(posedge Clk) begin
      cyc <= cyc + 1;
      if (pre_en) rf[pre_addr] <= pre_data;
      else if (We) rf[W] <= Da;
      if (!Rst && We) begin
         wlog_addr[wn] <= W;
         wlog_data[wn] <= Da;
         wn <= wn + 1;
      end
      if (!Rst && In_Valid && In_Ready) begin
         acc_cyc[an] <= cyc;
         an <= an + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Drives one instruction from IDLE and checks every cycle up to retirement.
   task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [15:0] exp_da,
                        input logic exp_c, input logic exp_z);
      @(negedge Clk);
      chk("ready_before", In_Ready, 1);
      In_Valid = 1'b1; Op = op; Rd = rd; Rs1 = rs1; Rs2 = rs2;
      @(negedge Clk);
      In_Valid = 1'b0;
      chk("read_re1", Re1, rs1);
      chk("read_re2", Re2, rs2);
      chk("read_ready", In_Ready, 0);
      chk("read_we", We, 0);
      @(negedge Clk);
      chk("exec_we", We, 0);
      chk("exec_done", Done, 0);
      @(negedge Clk);
      chk("write_we", We, 1);
      chk("write_w", W, rd);
      chk("write_da", Da, exp_da);
      @(negedge Clk);
      chk("done", Done, 1);
      chk("done_we", We, 0);
      chk("done_ready", In_Ready, 1);
      chk("result", Result, exp_da);
      chk("carry", Carry, exp_c);
      chk("zero", Zero, exp_z);
   endtask

   logic [2:0] b_op  [12];
   logic [3:0] b_rd  [12];
   logic [3:0] b_rs1 [12];
   logic [3:0] b_rs2 [12];
   int wn0, an0;

   initial begin
      // Reset for 16 cycles while preloading rf[k] = k.
      for (int k = 0; k < 16; k++) begin
         @(negedge Clk);
         pre_en = 1'b1; pre_addr = 4'(k); pre_data = 16'(k);
      end
      @(negedge Clk);
      pre_en = 1'b0;
      Rst = 1'b0;
      chk("rst_ready", In_Ready, 1);
      chk("rst_we", We, 0);
      chk("rst_done", Done, 0);
      chk("rst_result", Result, 0);
      chk("rst_zero", Zero, 0);
      chk("rst_carry", Carry, 0);
      chk("rst_w", W, 0);
      chk("rst_da", Da, 0);

      issue(3'd0, 4'd9, 4'd3, 4'd5, 16'h0008, 1'b0, 1'b0);
      issue(3'd1, 4'd10, 4'd2, 4'd7, 16'hFFFB, 1'b1, 1'b0);
      issue(3'd1, 4'd11, 4'd4, 4'd4, 16'h0000, 1'b0, 1'b1);

      @(negedge Clk);
      pre_en = 1'b1; pre_addr = 4'd1; pre_data = 16'h8001;
      @(negedge Clk);
      pre_en = 1'b0;
      issue(3'd5, 4'd1, 4'd1, 4'd0, 16'h0002, 1'b1, 1'b0);
      issue(3'd7, 4'd2, 4'd1, 4'd0, 16'h0002, 1'b0, 1'b0);
      chk("mov_rf2", rf[2], 16'h0002);

      // Back-to-back: In_Valid held for 12 cycles; only slots 0, 4, 8 may be accepted.
      for (int i = 0; i < 12; i++) begin
         b_op[i] = 3'd0; b_rd[i] = 4'd15; b_rs1[i] = 4'd15; b_rs2[i] = 4'd15;
      end
      b_op[0] = 3'd2; b_rd[0] = 4'd12; b_rs1[0] = 4'd3;  b_rs2[0] = 4'd5;
      b_op[4] = 3'd3; b_rd[4] = 4'd13; b_rs1[4] = 4'd6;  b_rs2[4] = 4'd9;
      b_op[8] = 3'd4; b_rd[8] = 4'd0;  b_rs1[8] = 4'd12; b_rs2[8] = 4'd13;
      wn0 = wn;
      an0 = an;
      for (int i = 0; i < 12; i++) begin
         @(negedge Clk);
         In_Valid = 1'b1; Op = b_op[i]; Rd = b_rd[i]; Rs1 = b_rs1[i]; Rs2 = b_rs2[i];
      end
      @(negedge Clk);
      In_Valid = 1'b0;
      repeat (4) @(negedge Clk);
      chk("b2b_accepts", an - an0, 3);
      chk("b2b_writes", wn - wn0, 3);
      chk("b2b_gap1", acc_cyc[an0 + 1] - acc_cyc[an0], 4);
      chk("b2b_gap2", acc_cyc[an0 + 2] - acc_cyc[an0], 8);
      chk("b2b_w0", wlog_addr[wn0], 12);
      chk("b2b_da0", wlog_data[wn0], 16'h0001);
      chk("b2b_w1", wlog_addr[wn0 + 1], 13);
      chk("b2b_da1", wlog_data[wn0 + 1], 16'h000E);
      chk("b2b_w2", wlog_addr[wn0 + 2], 0);
      chk("b2b_da2", wlog_data[wn0 + 2], 16'h000F);

      // rf[0] = 0xF is a real register: SHR gives 7 with shift-out 1.
      issue(3'd6, 4'd14, 4'd0, 4'd0, 16'h0007, 1'b1, 1'b0);

      // Reset during EXEC abandons the instruction.
      wn0 = wn;
      @(negedge Clk);
      In_Valid = 1'b1; Op = 3'd0; Rd = 4'd4; Rs1 = 4'd3; Rs2 = 4'd5;
      @(negedge Clk);
      In_Valid = 1'b0;
      @(negedge Clk);
      chk("mid_exec_we", We, 0);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      chk("mid_ready", In_Ready, 1);
      chk("mid_we", We, 0);
      chk("mid_done", Done, 0);
      chk("mid_result", Result, 0);
      repeat (4) begin
         @(negedge Clk);
         chk("mid_no_done", Done, 0);
      end
      chk("mid_no_write", wn - wn0, 0);
      chk("mid_rf4", rf[4], 16'h0004);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
